// File: rtl/button_stepper.sv
// Debounced push-button stepper: steps Led up/down through [LO, HI] with wrap-around.
// Optional hold-to-repeat stepping is compiled in with BUTTON_STEPPER_AUTOREPEAT_EN.
module button_stepper #(
  parameter int WIDTH           = 2,
  parameter int LO              = 1,
  parameter int HI              = 3,
  parameter int RESET_STATE     = 0,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p,
  input  logic             dir,
  output logic [WIDTH-1:0] Led,
  output logic             step_pulse
);

  localparam int                DCNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH:0]    LO_X      = (WIDTH + 1)'(LO);
  localparam logic [WIDTH:0]    HI_X      = (WIDTH + 1)'(HI);
  localparam logic [WIDTH-1:0]  LO_W      = WIDTH'(LO);
  localparam logic [WIDTH-1:0]  HI_W      = WIDTH'(HI);

  logic              s1;
  logic              s2;
  logic              deb;
  logic [DCNT_W-1:0] dcnt;
  logic              accept;
  logic              press;
  logic              fall;
  logic              rep_step;
  logic              step;
  logic [WIDTH:0]    led_ext;
  logic [WIDTH-1:0]  led_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= p;
      s2 <= s1;
    end
  end

  // A level change is accepted on the edge that completes DEBOUNCE_CYCLES of disagreement.
  always_comb begin
    accept = (s2 != deb) && (dcnt == DCNT_LAST);
    press  = accept && s2;
    fall   = accept && !s2;
    step   = press || rep_step;
  end

  // Extra bit keeps the range compares meaningful when HI is the all-ones state.
  assign led_ext = {1'b0, Led};

  always_comb begin
    led_next = Led;
    if (!dir) begin
      if ((led_ext >= HI_X) || (led_ext < LO_X)) led_next = LO_W;
      else                                        led_next = Led + WIDTH'(1);
    end else begin
      if ((led_ext <= LO_X) || (led_ext > HI_X)) led_next = HI_W;
      else                                        led_next = Led - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb        <= 1'b0;
      dcnt       <= '0;
      Led        <= WIDTH'(RESET_STATE);
      step_pulse <= 1'b0;
    end else begin
      if (s2 == deb) begin
        dcnt <= '0;
      end else if (accept) begin
        deb  <= s2;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + DCNT_W'(1);
      end
      step_pulse <= step;
      if (step) Led <= led_next;
    end
  end

`ifdef BUTTON_STEPPER_AUTOREPEAT_EN
  localparam int                HCNT_W    = $clog2(HOLD_CYCLES) + 1;
  localparam int                RCNT_W    = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HOLD_CYCLES - 1);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REPEAT_CYCLES - 1);

  logic [HCNT_W-1:0] hcnt;
  logic [RCNT_W-1:0] rcnt;
  logic              repeating;

  // deb is still 0 on the press edge, so counting starts on the following cycle.
  always_comb begin
    rep_step = 1'b0;
    if (deb && !fall) begin
      if (repeating) rep_step = (rcnt == RCNT_LAST);
      else           rep_step = (hcnt == HCNT_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt      <= '0;
      rcnt      <= '0;
      repeating <= 1'b0;
    end else if (!deb || fall) begin
      hcnt      <= '0;
      rcnt      <= '0;
      repeating <= 1'b0;
    end else if (repeating) begin
      rcnt <= rep_step ? '0 : rcnt + RCNT_W'(1);
    end else if (rep_step) begin
      hcnt      <= '0;
      repeating <= 1'b1;
    end else begin
      hcnt <= hcnt + HCNT_W'(1);
    end
  end
`else
  // Hold/repeat timing is inert in this build; legal values make this constant 0.
  assign rep_step = (HOLD_CYCLES < 0) && (REPEAT_CYCLES < 0);
`endif

endmodule
